bcd_scan_counter: RTL and testbench

Two-digit synchronous BCD up/down counter (00–99) with a tick prescaler and a time-multiplexed digit scanner. It sits directly upstream of the 7-segment decoder. Each scan slot presents one BCD nibble on `bcd[3:0]` (mapped MSB-first to the decoder's W,X,Y,Z inputs) together with an active-low digit enable, so one decoder drives a two-digit display.

---
 rtl/bcd_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_scan_counter.sv | 124 ++++++++++++
 tb/tb_bcd_scan_counter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD scan counter.
//   bcd_t      : one BCD nibble
//   bcd_pair_t : tens/ones nibble pair, laid out as load_val[7:4]/[3:0]
//   bcd_clean  : forces an out-of-range nibble to 0
package bcd_pkg;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam logic [1:0] DIG_ONES_N = 2'b10;
  localparam logic [1:0] DIG_TENS_N = 2'b01;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd_pair_t;

  function automatic bcd_t bcd_clean(input bcd_t v);
    return (v > BCD_MAX) ? 4'd0 : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD up/down counter.
//   clk, rst_n : clock, async active-low reset
//   clr, load  : synchronous clear / load (clr wins over load)
//   load_val   : nibble to load; values above 9 load as 0
//   step, up   : advance one count in the given direction
//   digit      : current digit, always 0..9
//   terminal   : digit is at the roll-over point for the current direction
//                (9 counting up, 0 counting down); feeds the next decade
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  bcd_t load_val,
  input  logic step,
  input  logic up,
  output bcd_t digit,
  output logic terminal
);

  assign terminal = up ? (digit == BCD_MAX) : (digit == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    digit <= 4'd0;
    else if (clr)  digit <= 4'd0;
    else if (load) digit <= bcd_clean(load_val);
    else if (step) begin
      if (up) digit <= terminal ? 4'd0    : digit + 4'd1;
      else    digit <= terminal ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter (00..99) with tick prescaler and a
// time-multiplexed digit scanner feeding a single 7-segment decoder.
//   TICK_DIV  : enabled cycles per count step (>=1)
//   SCAN_DIV  : cycles per scan slot (>=1)
//   clk, rst_n: clock, async active-low reset
//   en, up    : count enable (gates prescaler), direction (1 = up)
//   clr, load : synchronous clear / parallel load (clr > load > step)
//   load_val  : [7:4] tens, [3:0] ones
//   ones,tens : count digits
//   bcd,dig_n : scanned nibble and active-low digit enable ([0]=ones)
//   tick,wrap : one-cycle pulses after a step / after a 99<->00 roll
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int SCAN_DIV = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] bcd,
  output logic [1:0] dig_n,
  output logic       tick,
  output logic       wrap
);

  localparam int NUM_DIG = 2;
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMAX = SW'(SCAN_DIV - 1);

  bcd_pair_t lv;
  assign lv = load_val;

  // prescaler
  logic [PW-1:0] presc;
  logic          presc_tc, step;

  assign presc_tc = en && (presc == PMAX);
  // step only when neither clear nor load overrides this edge
  assign step     = presc_tc && !clr && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                presc <= '0;
    else if (clr || load)      presc <= '0;
    else if (en)               presc <= presc_tc ? '0 : presc + 1'b1;
  end

  // digit chain: each decade steps when all lower decades are terminal
  logic [NUM_DIG-1:0][3:0] digs;
  logic [NUM_DIG-1:0][3:0] ld_nib;
  logic [NUM_DIG-1:0]      term;
  logic [NUM_DIG:0]        stp;

  assign ld_nib[0] = lv.ones;
  assign ld_nib[1] = lv.tens;
  assign stp[0]    = step;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIG; gi++) begin : g_dig
      bcd_digit u_dig (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (load),
        .load_val (ld_nib[gi]),
        .step     (stp[gi]),
        .up       (up),
        .digit    (digs[gi]),
        .terminal (term[gi])
      );
      assign stp[gi+1] = stp[gi] && term[gi];
    end
  endgenerate

  assign ones = digs[0];
  assign tens = digs[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= step;
      wrap <= stp[NUM_DIG];
    end
  end

  // free-running scanner, independent of en/clr/load
  logic [SW-1:0] scnt;
  logic          sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt <= '0;
      sel  <= 1'b0;
    end else if (scnt == SMAX) begin
      scnt <= '0;
      sel  <= ~sel;
    end else begin
      scnt <= scnt + 1'b1;
    end
  end

  // bcd and dig_n share one register stage so they switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd   <= 4'd0;
      dig_n <= DIG_ONES_N;
    end else begin
      bcd   <= sel ? tens : ones;
      dig_n <= sel ? DIG_TENS_N : DIG_ONES_N;
    end
  end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Self-checking bench for bcd_scan_counter (TICK_DIV=4, SCAN_DIV=2):
// directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against an arithmetic model.
module tb_bcd_scan_counter;

  localparam int TD = 4;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ones, tens, bcd;
  logic [1:0] dig_n;
  logic       tick, wrap;

  bcd_scan_counter #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .ones(ones), .tens(tens), .bcd(bcd),
    .dig_n(dig_n), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int cnt, presc, cyc;
  int m_bcd, m_dig, m_tick, m_wrap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt = 0; presc = 0; cyc = 0;
      m_bcd = 0; m_dig = 2; m_tick = 0; m_wrap = 0;
    end else begin
      int sel_now, t, o;
      // scanner slot is a pure function of elapsed edges since reset
      sel_now = (cyc / SD) % 2;
      m_bcd = sel_now ? cnt / 10 : cnt % 10;
      m_dig = sel_now ? 1 : 2;
      cyc++;
      m_tick = 0; m_wrap = 0;
      if (clr) begin
        cnt = 0; presc = 0;
      end else if (load) begin
        t = load_val[7:4]; o = load_val[3:0];
        if (t > 9) t = 0;
        if (o > 9) o = 0;
        cnt = t * 10 + o; presc = 0;
      end else if (en) begin
        if (presc == TD - 1) begin
          presc = 0; m_tick = 1;
          if (up) begin m_wrap = (cnt == 99); cnt = (cnt + 1) % 100; end
          else    begin m_wrap = (cnt == 0);  cnt = (cnt + 99) % 100; end
        end else presc++;
      end
    end
  end

  bit chk_on = 1'b0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("ones",  ones,  cnt % 10);
      chk("tens",  tens,  cnt / 10);
      chk("bcd",   bcd,   m_bcd);
      chk("dig_n", dig_n, m_dig);
      chk("tick",  tick,  m_tick);
      chk("wrap",  wrap,  m_wrap);
      chk("dig_n_nonzero", (dig_n == 2'b00), 0);
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_cnt(input string name, input int t, input int o);
    chk({name, "_tens"}, tens, t);
    chk({name, "_ones"}, ones, o);
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_ones"},  ones,  0);
    chk({name, "_tens"},  tens,  0);
    chk({name, "_bcd"},   bcd,   0);
    chk({name, "_dig_n"}, dig_n, 2);
    chk({name, "_tick"},  tick,  0);
    chk({name, "_wrap"},  wrap,  0);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    chk_on = 1'b1;
    @(negedge clk); rst_n = 1'b1;

    // scanner while idle: dig_n alternates every 2 cycles, bcd stays 0
    cyc_n(2); chk("scan_a", dig_n, 2);
    cyc_n(1); chk("scan_b", dig_n, 1); chk("scan_bcd", bcd, 0);
    cyc_n(2); chk("scan_c", dig_n, 2);

    // count up: first tick after 4 cycles, 10 steps -> 10
    en = 1'b1; up = 1'b1;
    cyc_n(3); chk("tick_early", tick, 0);
    cyc_n(1); chk("tick_first", tick, 1); chk_cnt("step1", 0, 1);
    cyc_n(36); chk_cnt("ten_steps", 1, 0); chk("tick_ten", tick, 1);

    // 98 -> 99 -> 00 with wrap
    load = 1'b1; load_val = 8'h98; cyc_n(1); load = 1'b0;
    chk_cnt("ld98", 9, 8);
    cyc_n(4); chk_cnt("to99", 9, 9); chk("wrap99_n", wrap, 0);
    cyc_n(4); chk_cnt("to00", 0, 0); chk("wrap_up", wrap, 1);
    cyc_n(1); chk("wrap_pulse", wrap, 0);

    // count down from 00
    clr = 1'b1; cyc_n(1); clr = 1'b0; up = 1'b0;
    cyc_n(4); chk_cnt("dn99", 9, 9); chk("wrap_dn", wrap, 1);
    cyc_n(4); chk_cnt("dn98", 9, 8); chk("wrap_dn98", wrap, 0);
    chk("tick_dn98", tick, 1);

    // loads and clear priority
    en = 1'b0;
    load = 1'b1; load_val = 8'h47; cyc_n(1);
    chk_cnt("ld47", 4, 7);
    load_val = 8'hA3; cyc_n(1); chk_cnt("ldA3", 0, 3);
    load_val = 8'h5F; cyc_n(1); chk_cnt("ld5F", 5, 0);
    clr = 1'b1; load_val = 8'h66; cyc_n(1); chk_cnt("ldclr", 0, 0);
    clr = 1'b0; load_val = 8'h25; cyc_n(1); load = 1'b0;

    // clear on the step edge suppresses the tick
    en = 1'b1; up = 1'b1;
    cyc_n(3); clr = 1'b1; cyc_n(1); clr = 1'b0;
    chk_cnt("clr_step", 0, 0); chk("clr_tick", tick, 0);

    // enable hold: 2 cycles, pause 10, resume -> step 2 cycles later
    cyc_n(2); en = 1'b0;
    cyc_n(10); chk_cnt("hold", 0, 0); chk("hold_tick", tick, 0);
    en = 1'b1;
    cyc_n(1); chk("resume1", tick, 0);
    cyc_n(1); chk("resume2", tick, 1); chk_cnt("resume", 0, 1);

    // async reset between edges at count 56
    en = 1'b0; load = 1'b1; load_val = 8'h56; cyc_n(1); load = 1'b0;
    cyc_n(2);
    chk_cnt("pre_rst", 5, 6);
    @(posedge clk); #2 rst_n = 1'b0; #1;
    chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;

    // randomized run
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) up = ~up;
      clr      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 59) == 0);
      load_val = 8'($urandom);
      if ($urandom_range(0, 999) == 0) begin
        @(posedge clk); #3 rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
      end else cyc_n(1);
    end
    en = 1'b0; clr = 1'b0; load = 1'b0;
    cyc_n(2);
    chk_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
